ahb_sif: RTL and testbench
==========================

AHB_SIF -- requirements
Module: ahb_sif

Interface
- REQ-001: Parameter MEM_ABITS, default 16; byte-address bits of the internal memory (2^MEM_ABITS bytes).
- REQ-002: Parameter MAILBOX_ADDR, default 32'hD058_0000; mailbox byte address.
- REQ-003: Reset is asynchronous and active-high on HRESETn; one clock, HCLK.
- REQ-004: HCLK  in  1  clock; all state updates on rising edge.
- REQ-005: HRESETn  in  1  asynchronous reset, active-high.
- REQ-006: HSEL  in  1  slave select.
- REQ-007: HADDR  in  32  byte address.
- REQ-008: HTRANS  in  2  transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- REQ-009: HWRITE  in  1  1 = write.
- REQ-010: HSIZE  in  3  0 byte, 1 half, 2 word, 3 dword; values above 3 treated as 3.
- REQ-011: HBURST  in  3 and HPROT  in  4; accepted, ignored.
- REQ-012: HREADY  in  1  bus-ready input from the interconnect.
- REQ-013: HWDATA  in  64  write data, data phase.
- REQ-014: HREADYOUT  out  1  slave ready.
- REQ-015: HRESP  out  1  response; constant 0 (OKAY).
- REQ-016: HRDATA  out  64  read data, data phase.
- REQ-017: mailbox_write  out  1  one-cycle pulse per mailbox write.
- REQ-018: WriteData  out  64  HWDATA of the last completed write.

Function
- REQ-019: An address phase is accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS[1]=1; the slave latches HADDR, HWRITE and HSIZE, and the next cycle is the data phase.
- REQ-020: IDLE or BUSY, HSEL=0, or HREADY=0 does not start a transfer.
- REQ-021: HREADYOUT is constant 1 (zero wait states), including during reset.
- REQ-022: Memory is byte-addressed; index = latched HADDR[MEM_ABITS-1:0]; higher address bits are ignored, so addresses wrap modulo 2^MEM_ABITS.
- REQ-023: Read data phase: HRDATA drives the 8 bytes at the doubleword-aligned latched address (bits [2:0] cleared), byte 0 on [7:0]; combinational from memory; size-independent.
- REQ-024: Outside a read data phase, HRDATA holds the doubleword addressed by the most recently latched address.
- REQ-025: Write data phase: byte lanes (1<<HSIZE) starting at latched HADDR[2:0] are written from the matching HWDATA lanes; lanes past byte 7 are dropped; the write commits at the rising edge ending the data phase.
- REQ-026: Back-to-back write then read of the same address returns the new data; no forwarding logic is needed because the write commits before the read's data phase.
- REQ-027: Write data phase: WriteData is registered with HWDATA at the ending edge.
- REQ-028: If the latched write address equals MAILBOX_ADDR (all 32 bits), mailbox_write is 1 for exactly the following cycle and memory is not updated.
- REQ-029: Memory contents are initialisable by simulation preload (hex, byte-per-entry).

Reset
- REQ-030: While HRESETn=1: the data-phase-valid flag clears, mailbox_write=0, WriteData=0, latched address=0, HRESP=0.
- REQ-031: Memory is not cleared by reset.
- REQ-032: Reset asserted mid data phase aborts the write; memory is unchanged.
- REQ-033: The first transfer is accepted on the first rising edge after HRESETn falls.

Structure
- REQ-034: Shared package ahb_pkg holds the HTRANS and HSIZE encodings and the MAILBOX_ADDR default.
- REQ-035: One sub-module, ahb_sif_mem, implements the byte-enable memory array: 8 lane enables, one write port, one combinational 64-bit read port.
- REQ-036: The top level contains the address-phase register, lane-strobe decode and mailbox logic only.

Verification
- REQ-037: Preload bytes 0x00..0x07 with 0x11..0x88; dword read at 0x0 -> HRDATA=64'h8877665544332211 in the data phase.
- REQ-038: Byte write 0xAB at 0x5, then dword read at 0x0 -> HRDATA=64'h8877AB5544332211; word write of HWDATA[63:32]=0xDEADBEEF at 0x4 -> read = 64'hDEADBEEF44332211.
- REQ-039: Write 64'h0000_0000_0000_0048 at 0xD0580000 -> mailbox_write pulses one cycle, WriteData[7:0]=0x48, memory unchanged; a write of 0xFF likewise pulses with WriteData[7:0]=0xFF.
- REQ-040: NONSEQ read at 0x10 with HREADY=0, then IDLE, then BUSY -> no transfer, memory and WriteData unchanged, HRESP=0 throughout.
- REQ-041: Assert HRESETn during a write data phase to 0x8 -> memory at 0x8 unchanged, mailbox_write=0, WriteData=0.
- REQ-042: Read at 0x1_0000 with MEM_ABITS=16 -> data from 0x0 (wrap).

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB encodings (HTRANS, HSIZE), the default mailbox
//                address and the byte-lane helper functions used by the
//                AHB slave memory interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic [31:0] MAILBOX_ADDR_DEFAULT = 32'hD058_0000;
    localparam int unsigned BUS_LANES            = 8;

    // The data bus is 64 bits wide, so anything larger than a doubleword
    // collapses onto a doubleword.
    function automatic logic [1:0] clamp_size(input logic [2:0] size);
        return (size > 3'd3) ? 2'd3 : size[1:0];
    endfunction

    // Byte lanes [offset, offset + 2**size) of the 8-lane bus. The end index
    // is computed in 4 bits so lanes that would spill past byte 7 simply
    // never match and are dropped.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset,
                                             input logic [1:0] size);
        logic [3:0] lane_end;
        logic [7:0] mask;
        lane_end = {1'b0, offset} + (4'd1 << size);
        mask     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if ((4'(i) >= {1'b0, offset}) && (4'(i) < lane_end)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sif_mem.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sif_mem
//  Description : Byte-addressed memory array with eight independent byte-lane
//                write enables, one synchronous write port and one
//                combinational 64-bit read port on the same doubleword index.
//  Ports       : clk      - write clock
//                lane_we  - per-byte write enables (lane 0 = bits [7:0])
//                dw_addr  - doubleword index (byte address bits [MSB:3])
//                wdata    - write data, lane-aligned
//                rdata    - doubleword at dw_addr, byte 0 on [7:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sif_mem
    import ahb_pkg::*;
#(
    parameter int MEM_ABITS = 16
) (
    input  logic                 clk,
    input  logic [7:0]           lane_we,
    input  logic [MEM_ABITS-4:0] dw_addr,
    input  logic [63:0]          wdata,
    output logic [63:0]          rdata
);

    localparam int unsigned c_DEPTH = 2 ** MEM_ABITS;

    // One byte per entry so a byte-per-line hex image maps straight onto it.
    // There is deliberately no reset: contents survive a bus reset.
    logic [7:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < BUS_LANES; i++) begin
            if (lane_we[i]) begin
                r_mem[{dw_addr, 3'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    generate
        for (genvar g = 0; g < BUS_LANES; g++) begin : g_rd_lane
            assign rdata[8*g +: 8] = r_mem[{dw_addr, 3'(g)}];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ahb_sif.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sif
//  Description : Zero-wait-state AHB slave in front of a byte-addressed
//                memory, with a write-only mailbox at MAILBOX_ADDR that
//                pulses mailbox_write instead of updating memory.
//  Ports       : HCLK, HRESETn (async, active-high)     - clock / reset
//                HSEL HADDR HTRANS HWRITE HSIZE HBURST
//                HPROT HREADY HWDATA                    - AHB slave inputs
//                HREADYOUT HRESP HRDATA                 - AHB slave outputs
//                mailbox_write                          - 1-cycle mailbox pulse
//                WriteData                              - last written HWDATA
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sif
    import ahb_pkg::*;
#(
    parameter int          MEM_ABITS    = 16,
    parameter logic [31:0] MAILBOX_ADDR = MAILBOX_ADDR_DEFAULT
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [63:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [63:0] HRDATA,
    output logic        mailbox_write,
    output logic [63:0] WriteData
);

    // ------------------------------------------------------------------
    // Address-phase register
    // ------------------------------------------------------------------
    logic        r_valid;   // a data phase is in progress this cycle
    logic        r_write;
    logic [31:0] r_addr;
    logic [1:0]  r_size;

    logic        w_accept;
    logic        w_wr_phase;
    logic        w_mbox_hit;
    logic [7:0]  w_lane_we;

    // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY do not.
    assign w_accept   = HSEL && HREADY && HTRANS[1];
    assign w_wr_phase = r_valid && r_write;
    assign w_mbox_hit = (r_addr == MAILBOX_ADDR);

    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= 32'h0;
            r_size  <= 2'd0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_write <= HWRITE;
                r_addr  <= HADDR;
                r_size  <= clamp_size(HSIZE);
            end
        end
    end

    // ------------------------------------------------------------------
    // Mailbox and write-data capture. Both update at the edge that ends a
    // write data phase, so the pulse covers the cycle after that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            mailbox_write <= 1'b0;
            WriteData     <= 64'h0;
        end else begin
            mailbox_write <= w_wr_phase && w_mbox_hit;
            if (w_wr_phase) begin
                WriteData <= HWDATA;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane-strobe decode. r_valid is cleared asynchronously, so a reset that
    // lands inside a write data phase drops the strobes before the commit
    // edge and the write is lost.
    // ------------------------------------------------------------------
    assign w_lane_we = (w_wr_phase && !w_mbox_hit) ? lane_mask(r_addr[2:0], r_size)
                                                   : 8'h00;

    // Read port always follows the latched address, so HRDATA keeps showing
    // the last addressed doubleword between transfers.
    ahb_sif_mem #(
        .MEM_ABITS (MEM_ABITS)
    ) u_mem (
        .clk     (HCLK),
        .lane_we (w_lane_we),
        .dw_addr (r_addr[MEM_ABITS-1:3]),
        .wdata   (HWDATA),
        .rdata   (HRDATA)
    );

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Burst type, protection and the NONSEQ/SEQ distinction carry no meaning
    // for a single-cycle memory.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, HBURST, HPROT, HTRANS[0]};

endmodule
`default_nettype wire

// File: tb/tb_ahb_sif.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_sif
//  Description : Self-checking bench for ahb_sif. Read expectations are
//                pushed to a scoreboard queue when the address phase is
//                driven and popped when the data phase is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sif;
    import ahb_pkg::*;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = 32'h0;
    logic [1:0]  HTRANS  = 2'd0;
    logic        HWRITE  = 1'b0;
    logic [2:0]  HSIZE   = 3'd0;
    logic [2:0]  HBURST  = 3'd0;
    logic [3:0]  HPROT   = 4'd0;
    logic        HREADY  = 1'b1;
    logic [63:0] HWDATA  = 64'h0;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        mailbox_write;
    logic [63:0] WriteData;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    ahb_sif #(
        .MEM_ABITS    (16),
        .MAILBOX_ADDR (32'hD058_0000)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HWRITE        (HWRITE),
        .HSIZE         (HSIZE),
        .HBURST        (HBURST),
        .HPROT         (HPROT),
        .HREADY        (HREADY),
        .HWDATA        (HWDATA),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .mailbox_write (mailbox_write),
        .WriteData     (WriteData)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- stimulus helpers (inputs change on negedge) ----------
    task automatic addr_phase(input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [1:0] tr);
        HSEL = 1'b1; HREADY = 1'b1; HWRITE = wr; HADDR = a; HSIZE = sz; HTRANS = tr;
    endtask

    task automatic go_idle();
        HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HREADY = 1'b1;
    endtask

    // Returns at the negedge after the commit edge.
    task automatic write_single(input logic [31:0] a, input logic [2:0] sz,
                                input logic [63:0] d);
        @(negedge HCLK); addr_phase(1'b1, a, sz, HTRANS_NONSEQ);
        @(negedge HCLK); go_idle(); HWDATA = d;
        @(negedge HCLK);
    endtask

    // Returns in the middle of the read data phase.
    task automatic read_issue(input logic [31:0] a, input logic [63:0] e);
        @(negedge HCLK); addr_phase(1'b0, a, HSIZE_DWORD, HTRANS_NONSEQ);
        exp_q.push_back(e);
        @(negedge HCLK); go_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] e;
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);
        checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
        checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", HRESP); end
        checks++; if (mailbox_write !== 1'b0) begin failures++; $display("FAIL reset_mailbox got=%b exp=0", mailbox_write); end
        e = 64'h0;
        checks++; if (WriteData !== e) begin failures++; $display("FAIL reset_writedata got=%h exp=%h", WriteData, e); end
    endtask

    task automatic test_preload_read();
        logic [63:0] e;
        // Release reset and present the first address phase in the same
        // cycle: it must be accepted on the very next rising edge.
        @(negedge HCLK);
        HRESETn = 1'b0;
        addr_phase(1'b1, 32'h0, HSIZE_BYTE, HTRANS_NONSEQ);
        @(negedge HCLK); go_idle(); HWDATA = 64'h11;
        @(negedge HCLK);
        for (int i = 1; i < 8; i++) begin
            write_single(32'(i), HSIZE_BYTE, 64'(8'h11 * (i + 1)) << (8 * i));
        end
        read_issue(32'h0, 64'h8877_6655_4433_2211);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL preload_read got=%h exp=%h", HRDATA, e); end
    endtask

    task automatic test_byte_word_write();
        logic [63:0] e;
        write_single(32'h5, HSIZE_BYTE, 64'h0000_AB00_0000_0000);
        read_issue(32'h0, 64'h8877_AB55_4433_2211);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL byte_write got=%h exp=%h", HRDATA, e); end
        write_single(32'h4, HSIZE_WORD, 64'hDEAD_BEEF_0000_0000);
        read_issue(32'h0, 64'hDEAD_BEEF_4433_2211);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL word_write got=%h exp=%h", HRDATA, e); end
        // Oversized HSIZE at offset 6: only lanes 6 and 7 survive.
        write_single(32'h6, 3'd7, 64'h1234_5678_9ABC_DEF0);
        read_issue(32'h0, 64'h1234_BEEF_4433_2211);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL size_clamp_drop got=%h exp=%h", HRDATA, e); end
    endtask

    task automatic test_mailbox();
        logic [63:0] e;
        logic [7:0]  mb [2];
        mb[0] = 8'h48; mb[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            write_single(32'hD058_0000, HSIZE_DWORD, {56'h0, mb[k]});
            checks++; if (mailbox_write !== 1'b1) begin failures++; $display("FAIL mailbox_pulse[%0d] got=%b exp=1", k, mailbox_write); end
            checks++; if (WriteData[7:0] !== mb[k]) begin failures++; $display("FAIL mailbox_data[%0d] got=%h exp=%h", k, WriteData[7:0], mb[k]); end
            @(negedge HCLK);
            checks++; if (mailbox_write !== 1'b0) begin failures++; $display("FAIL mailbox_single[%0d] got=%b exp=0", k, mailbox_write); end
        end
        // The mailbox aliases byte 0 of memory; it must not have been written.
        read_issue(32'h0, 64'h1234_BEEF_4433_2211);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL mailbox_mem got=%h exp=%h", HRDATA, e); end
    endtask

    task automatic test_no_transfer();
        logic [63:0] e;
        logic [63:0] wd;
        wd = 64'h0102_0304_0506_0708;
        write_single(32'h10, HSIZE_DWORD, wd);
        for (int p = 0; p < 5; p++) begin
            @(negedge HCLK);
            case (p)
                0: begin addr_phase(1'b0, 32'h10, HSIZE_DWORD, HTRANS_NONSEQ); HREADY = 1'b0; end
                1: begin addr_phase(1'b1, 32'h10, HSIZE_DWORD, HTRANS_NONSEQ); HREADY = 1'b0; end
                2: addr_phase(1'b1, 32'h10, HSIZE_DWORD, HTRANS_IDLE);
                3: addr_phase(1'b1, 32'h10, HSIZE_DWORD, HTRANS_BUSY);
                default: begin addr_phase(1'b1, 32'h10, HSIZE_DWORD, HTRANS_NONSEQ); HSEL = 1'b0; end
            endcase
            HWDATA = 64'hFFFF_FFFF_FFFF_FFFF;
            @(posedge HCLK); #1;
            checks++; if (HRESP !== 1'b0) begin failures++; $display("FAIL idle_hresp[%0d] got=%b exp=0", p, HRESP); end
            checks++; if (HRDATA !== wd) begin failures++; $display("FAIL idle_hrdata_hold[%0d] got=%h exp=%h", p, HRDATA, wd); end
        end
        @(negedge HCLK); go_idle();
        @(negedge HCLK);
        checks++; if (WriteData !== wd) begin failures++; $display("FAIL idle_writedata got=%h exp=%h", WriteData, wd); end
        checks++; if (mailbox_write !== 1'b0) begin failures++; $display("FAIL idle_mailbox got=%b exp=0", mailbox_write); end
        read_issue(32'h10, wd);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL idle_mem got=%h exp=%h", HRDATA, e); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d, e;
        logic [7:0]  b;
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = 32'h20 + 32'(8 * k);
            d = {$urandom, $urandom};
            @(negedge HCLK); addr_phase(1'b1, a, HSIZE_DWORD, HTRANS_NONSEQ);
            @(negedge HCLK); addr_phase(1'b0, a, HSIZE_DWORD, HTRANS_SEQ); HWDATA = d;
            exp_q.push_back(d);
            @(negedge HCLK); go_idle();
            e = exp_q.pop_front();
            checks++; if (HRDATA !== e) begin failures++; $display("FAIL b2b_dword[%0d] got=%h exp=%h", k, HRDATA, e); end
            // Byte write into lane 3 of the same doubleword, read right after.
            b = 8'($urandom);
            @(negedge HCLK); addr_phase(1'b1, a + 32'h3, HSIZE_BYTE, HTRANS_NONSEQ);
            @(negedge HCLK); addr_phase(1'b0, a, HSIZE_DWORD, HTRANS_NONSEQ); HWDATA = {4{b, b}};
            e = d; e[31:24] = b;
            exp_q.push_back(e);
            @(negedge HCLK); go_idle();
            e = exp_q.pop_front();
            checks++; if (HRDATA !== e) begin failures++; $display("FAIL b2b_byte[%0d] got=%h exp=%h", k, HRDATA, e); end
            checks++; if (WriteData !== {4{b, b}}) begin failures++; $display("FAIL b2b_writedata[%0d] got=%h exp=%h", k, WriteData, {4{b, b}}); end
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] e;
        write_single(32'h8, HSIZE_DWORD, 64'h0123_4567_89AB_CDEF);
        @(negedge HCLK); addr_phase(1'b1, 32'h8, HSIZE_DWORD, HTRANS_NONSEQ);
        @(negedge HCLK); go_idle(); HWDATA = 64'hFFFF_FFFF_FFFF_FFFF; HRESETn = 1'b1;
        @(negedge HCLK);
        checks++; if (mailbox_write !== 1'b0) begin failures++; $display("FAIL abort_mailbox got=%b exp=0", mailbox_write); end
        checks++; if (WriteData !== 64'h0) begin failures++; $display("FAIL abort_writedata got=%h exp=0", WriteData); end
        e = 64'h1234_BEEF_4433_2211;   // latched address back at 0
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL abort_hrdata_addr0 got=%h exp=%h", HRDATA, e); end
        HRESETn = 1'b0;
        read_issue(32'h8, 64'h0123_4567_89AB_CDEF);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL abort_mem got=%h exp=%h", HRDATA, e); end
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        read_issue(32'h0001_0000, 64'h1234_BEEF_4433_2211);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL wrap_read got=%h exp=%h", HRDATA, e); end
        write_single(32'h8001_0038, HSIZE_DWORD, 64'h5A5A_A5A5_3C3C_C3C3);
        read_issue(32'h38, 64'h5A5A_A5A5_3C3C_C3C3);
        e = exp_q.pop_front();
        checks++; if (HRDATA !== e) begin failures++; $display("FAIL wrap_write got=%h exp=%h", HRDATA, e); end
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_byte_word_write();
        test_mailbox();
        test_no_transfer();
        test_back_to_back();
        test_reset_abort();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
